// File: rtl/cook_timer.sv
// cook_timer: microwave cook-time controller with BCD mm:ss countdown,
// keypad entry, +30 s quick start, stop/clear, door interlock and end beep.
module cook_timer #(
   parameter int DONE_CYCLES = 300,
   parameter int ADD_TENS    = 3
) (
   input  logic       clk_100Hz,
   input  logic       rst_n,
   input  logic       sec_in,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       door_open,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       heating,
   output logic       beep,
   output logic [2:0] state
);
   localparam int CW = $clog2(DONE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DONE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t cur, nxt;
   logic [15:0] tm, tm_n, tm_add, tm_dec;
   logic [CW-1:0] cnt, cnt_n;
   logic sec_in_d, tick;
   logic [3:0] mt, mo, st, so;
   logic [4:0] t_sum, mo_sum, mt_sum;
   logic [1:0] inc;
   logic [3:0] t_norm, mo_new;
   logic carry;

   assign {mt, mo, st, so} = tm;
   assign {min_tens, min_ones, sec_tens, sec_ones} = tm;
   assign state = cur;
   assign tick = sec_in & ~sec_in_d;

   // +30 s: fold seconds-tens of 6..12 back into minutes, saturate past 99 min
   assign t_sum  = 5'(st) + 5'(ADD_TENS);
   assign inc    = t_sum >= 5'd12 ? 2'd2 : t_sum >= 5'd6 ? 2'd1 : 2'd0;
   assign t_norm = 4'(t_sum - 5'(inc) * 5'd6);
   assign mo_sum = 5'(mo) + 5'(inc);
   assign carry  = mo_sum >= 5'd10;
   assign mo_new = 4'(carry ? mo_sum - 5'd10 : mo_sum);
   assign mt_sum = 5'(mt) + 5'(carry);
   assign tm_add = mt_sum > 5'd9 ? 16'h9959 : {mt_sum[3:0], mo_new, t_norm, so};

   // seconds may hold 60..99 from entry; borrow only refills to 59
   assign tm_dec = so != 4'd0 ? {mt, mo, st, so - 4'd1} :
                   st != 4'd0 ? {mt, mo, st - 4'd1, 4'd9} :
                   mo != 4'd0 ? {mt, mo - 4'd1, 4'd5, 4'd9} :
                                {mt - 4'd1, 4'd9, 4'd5, 4'd9};

   always_comb begin
      nxt   = cur;
      tm_n  = tm;
      cnt_n = cnt;
      if (cur == COOK && door_open) nxt = PAUSE;
      else if (stop) begin
         nxt = cur == COOK ? PAUSE : IDLE;
         if (cur != COOK && cur != DONE) tm_n = '0;
      end else if (start && !door_open) begin
         if (cur == COOK) tm_n = tm_add;
         else if (cur == DONE) nxt = IDLE;
         else begin
            nxt = COOK;
            if (cur != PAUSE && tm == '0) tm_n = 16'h0030;
         end
      end else if (key_valid && cur != COOK && cur != PAUSE) begin
         if (cur == DONE) nxt = IDLE;
         else if (key_digit <= 4'd9) begin
            nxt  = ENTRY;
            tm_n = {tm[11:0], key_digit};
         end
      end else if (tick && cur == COOK) begin
         tm_n = tm_dec;
         if (tm_dec == '0) begin
            nxt   = DONE;
            cnt_n = CNT_LOAD;
         end
      end else if (cur == DONE) begin
         if (cnt == '0) nxt = IDLE;
         else cnt_n = cnt - CW'(1);
      end
   end

   always_ff @(posedge clk_100Hz or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= IDLE;
         tm       <= '0;
         cnt      <= '0;
         sec_in_d <= 1'b0;
         heating  <= 1'b0;
         beep     <= 1'b0;
      end else begin
         cur      <= nxt;
         tm       <= tm_n;
         cnt      <= cnt_n;
         sec_in_d <= sec_in;
         heating  <= nxt == COOK;
         beep     <= nxt == DONE;
      end
   end
endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: scoreboard bench for cook_timer; expected {state,mm:ss,heating,beep}
// is queued with each stimulus cycle and compared after the clock edge.
module tb_cook_timer;
   localparam logic [2:0] IDLE = 3'd0, ENTRY = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4;

   logic clk = 1'b0, rst_n = 1'b1, sec_in = 1'b0, key_valid = 1'b0;
   logic start = 1'b0, stop = 1'b0, door_open = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic heating, beep;
   logic [2:0] state;
   logic [20:0] obs;
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      string       tag;
      logic [20:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   cook_timer dut (
      .clk_100Hz(clk), .rst_n(rst_n), .sec_in(sec_in), .key_valid(key_valid),
      .key_digit(key_digit), .start(start), .stop(stop), .door_open(door_open),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .heating(heating), .beep(beep), .state(state)
   );

   assign obs = {state, min_tens, min_ones, sec_tens, sec_ones, heating, beep};

   function automatic logic [15:0] bcd(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [20:0] pk(input logic [2:0] s, input logic [15:0] d);
      return {s, d, s == COOK, s == DONE};
   endfunction

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got st=%0d %h h=%b b=%b, want st=%0d %h h=%b b=%b", tag,
                  got[20:18], got[17:2], got[1], got[0], want[20:18], want[17:2], want[1], want[0]);
      end
   endtask

   task automatic step(input string tag, input logic kv, input logic [3:0] kd, input logic st,
                       input logic sp, input logic sec, input logic [2:0] es, input logic [15:0] ed);
      exp_t e;
      key_valid = kv;
      key_digit = kd;
      start     = st;
      stop      = sp;
      sec_in    = sec;
      e.tag = tag;
      e.exp = pk(es, ed);
      sb.push_back(e);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
   endtask

   task automatic press(input logic [3:0] d, input logic [2:0] es, input logic [15:0] ed);
      step("key", 1'b1, d, 1'b0, 1'b0, 1'b0, es, ed);
   endtask

   task automatic go(input logic [2:0] es, input logic [15:0] ed);
      step("start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, es, ed);
   endtask

   task automatic halt(input logic [2:0] es, input logic [15:0] ed);
      step("stop", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, es, ed);
   endtask

   task automatic tk(input logic [2:0] es, input logic [15:0] ed);
      step("tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, es, ed);
      step("tick_lo", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, es, ed);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 check("reset", obs, pk(IDLE, 16'h0000));
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;
      // 01:30 full countdown, then exactly 300 beep cycles
      press(4'd1, ENTRY, bcd(0, 1));
      press(4'd3, ENTRY, bcd(0, 13));
      press(4'd0, ENTRY, bcd(1, 30));
      go(COOK, bcd(1, 30));
      for (int k = 1; k <= 90; k++) begin
         if (90 - k > 0) tk(COOK, bcd((90 - k) / 60, (90 - k) % 60));
         else tk(DONE, 16'h0000);
      end
      for (int k = 0; k < 298; k++) step("beep", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, DONE, 16'h0000);
      step("beep_end", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, IDLE, 16'h0000);
      // five-digit entry, invalid digit, stop clears
      press(4'd9, ENTRY, bcd(0, 9));
      press(4'd9, ENTRY, bcd(0, 99));
      press(4'd9, ENTRY, bcd(9, 99));
      press(4'd9, ENTRY, bcd(99, 99));
      press(4'd5, ENTRY, bcd(99, 95));
      press(4'd12, ENTRY, bcd(99, 95));
      halt(IDLE, 16'h0000);
      // quick start and +30 s
      go(COOK, bcd(0, 30));
      go(COOK, bcd(1, 0));
      halt(PAUSE, bcd(1, 0));
      halt(IDLE, 16'h0000);
      press(4'd9, ENTRY, bcd(0, 9));
      press(4'd9, ENTRY, bcd(0, 99));
      press(4'd4, ENTRY, bcd(9, 94));
      press(4'd5, ENTRY, bcd(99, 45));
      go(COOK, bcd(99, 45));
      go(COOK, bcd(99, 59));
      halt(PAUSE, bcd(99, 59));
      halt(IDLE, 16'h0000);
      press(4'd1, ENTRY, bcd(0, 1));
      press(4'd9, ENTRY, bcd(0, 19));
      press(4'd5, ENTRY, bcd(1, 95));
      go(COOK, bcd(1, 95));
      go(COOK, bcd(3, 5));
      halt(PAUSE, bcd(3, 5));
      halt(IDLE, 16'h0000);
      // door interlock
      press(4'd1, ENTRY, bcd(0, 1));
      press(4'd0, ENTRY, bcd(0, 10));
      go(COOK, bcd(0, 10));
      door_open = 1'b1;
      step("door_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, PAUSE, bcd(0, 10));
      step("door_lo", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, PAUSE, bcd(0, 10));
      go(PAUSE, bcd(0, 10));
      door_open = 1'b0;
      go(COOK, bcd(0, 10));
      tk(COOK, bcd(0, 9));
      halt(PAUSE, bcd(0, 9));
      halt(IDLE, 16'h0000);
      // minute borrow and 60..99 seconds
      press(4'd2, ENTRY, bcd(0, 2));
      press(4'd0, ENTRY, bcd(0, 20));
      press(4'd0, ENTRY, bcd(2, 0));
      go(COOK, bcd(2, 0));
      tk(COOK, bcd(1, 59));
      halt(PAUSE, bcd(1, 59));
      halt(IDLE, 16'h0000);
      press(4'd1, ENTRY, bcd(0, 1));
      press(4'd7, ENTRY, bcd(0, 17));
      press(4'd5, ENTRY, bcd(1, 75));
      go(COOK, bcd(1, 75));
      for (int k = 1; k <= 76; k++) tk(COOK, 75 - k >= 0 ? bcd(1, 75 - k) : bcd(0, 59));
      halt(PAUSE, bcd(0, 59));
      halt(IDLE, 16'h0000);
      // tick on the start cycle is dropped; key in DONE aborts without capture
      press(4'd5, ENTRY, bcd(0, 5));
      step("start_tick", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, COOK, bcd(0, 5));
      step("start_lo", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, COOK, bcd(0, 5));
      for (int k = 4; k >= 1; k--) tk(COOK, bcd(0, k));
      tk(DONE, 16'h0000);
      press(4'd7, IDLE, 16'h0000);
      // asynchronous reset mid-cook with sec_in held high
      press(4'd5, ENTRY, bcd(0, 5));
      press(4'd0, ENTRY, bcd(0, 50));
      go(COOK, bcd(0, 50));
      tk(COOK, bcd(0, 49));
      sec_in = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("async_rst", obs, pk(IDLE, 16'h0000));
      @(posedge clk);
      #1 check("rst_held", obs, pk(IDLE, 16'h0000));
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) step("post_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, IDLE, 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
